// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e  : controller states (idle, shifting, result pulse)
//   WIDTH_MAX: largest supported operand width
//   fs_eval  : one-bit difference/borrow function, returns {borrow_out, difference}
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MAX = 32;

  function automatic logic [1:0] fs_eval(input logic a_bit, input logic b_bit, input logic brw);
    logic d;
    logic bnext;
    d     = a_bit ^ b_bit ^ brw;
    // Borrow when a<b outright, or when the bits are equal and a borrow is pending.
    bnext = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    return {bnext, d};
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational one-bit full-subtractor cell.
//   a_i, b_i : minuend / subtrahend bit
//   bin_i    : incoming borrow
//   d_o      : difference bit
//   bout_o   : outgoing borrow
module serial_subtractor_fs_cell
  import serial_subtractor_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic [1:0] res;

  always_comb begin
    res    = fs_eval(a_i, b_i, bin_i);
    d_o    = res[0];
    bout_o = res[1];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per clock, LSB first.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request, sampled only when not busy (idle or done state)
//   a, b, bin: operands and borrow-in, captured on an accepted start
//   busy     : high while bits are being shifted
//   done     : one-cycle pulse when diff/bout are valid
//   diff,bout: result and final borrow-out, held until the next accepted start
//   ovf      : signed overflow, present only when SERIAL_SUBTRACTOR_OVF_EN is defined
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range 2..32");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_d;
  logic cell_b;
  logic accept;
  logic last_bit;

  serial_subtractor_fs_cell u_cell (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .bin_i (brw_q),
    .d_o   (cell_d),
    .bout_o(cell_b)
  );

  // A start is honoured in idle and, for back-to-back operation, in the done cycle.
  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_bit = (state_q == StShift) && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StShift: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        brw_d  = cell_b;
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = StDone;
          done_d  = 1'b1;
          bout_d  = cell_b;
        end else begin
          busy_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StShift;
      a_sr_d  = a;
      b_sr_d  = b;
      brw_d   = bin;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    // On the last bit the cell output is the result MSB.
    if (last_bit) begin
      ovf_d = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance for directed, random, glitch and
// abort scenarios, and a 3-bit instance for an exhaustive back-to-back sweep. Expected results
// come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start3, bin3, busy3, done3, bout3;
  logic [2:0] a3, b3, diff3;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf8, ovf3;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .bin  (bin8),
    .busy (busy8),
    .done (done8),
    .diff (diff8),
    .bout (bout8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf  (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk  (clk),
    .rst  (rst),
    .start(start3),
    .a    (a3),
    .b    (b3),
    .bin  (bin3),
    .busy (busy3),
    .done (done3),
    .diff (diff3),
    .bout (bout3)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf  (ovf3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8,
               bout8);
    end
    checks++;
    if ({busy3, done3, diff3, bout3} !== 6'd0) begin
      errors++;
      $display("FAIL reset3: busy=%b done=%b diff=%h bout=%b, want all 0", busy3, done3, diff3,
               bout3);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checks++;
    if ({ovf8, ovf3} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ovf: ovf8=%b ovf3=%b, want 0", ovf8, ovf3);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One 8-bit operation; optionally pulses start with new operands mid-shift (glitch_at >= 0).
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input int glitch_at, input string nm);
    int         lat;
    int         busy_cnt;
    int         expv;
    int         extra;
    logic [7:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
    expv     = int'(ta) - int'(tb) - int'(tbin);
    exp_bout = (expv < 0);
    exp_diff = 8'(expv);
    exp_ovf  = (ta[7] ^ tb[7]) & (exp_diff[7] ^ ta[7]);

    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    // Operands change after capture and must not matter.
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      if (lat == glitch_at) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        start8 = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    start8 = 1'b0;

    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s latency: cycles to done=%0d, want 8", nm, lat);
    end
    checks++;
    if (busy_cnt !== 8) begin
      errors++;
      $display("FAIL %s busy_len: busy cycles=%0d, want 8", nm, busy_cnt);
    end
    checks++;
    if (diff8 !== exp_diff) begin
      errors++;
      $display("FAIL %s diff: got %h, want %h", nm, diff8, exp_diff);
    end
    checks++;
    if (bout8 !== exp_bout) begin
      errors++;
      $display("FAIL %s bout: got %b, want %b", nm, bout8, exp_bout);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checks++;
    if (ovf8 !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b, want %b", nm, ovf8, exp_ovf);
    end
`else
    if (exp_ovf) begin end
`endif
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done=%b one cycle later, want 0", nm, done8);
    end
    if (glitch_at >= 0) begin
      extra = 0;
      repeat (12) begin
        if (done8) extra++;
        @(negedge clk);
      end
      checks++;
      if (extra !== 0) begin
        errors++;
        $display("FAIL %s extra_done: %0d further done pulses, want 0", nm, extra);
      end
      checks++;
      if (diff8 !== exp_diff) begin
        errors++;
        $display("FAIL %s diff_hold: got %h, want %h", nm, diff8, exp_diff);
      end
    end
  endtask

  task automatic test_directed();
    op8(8'h05, 8'h03, 1'b0, -1, "dir_5_3");
    op8(8'h00, 8'h01, 1'b0, -1, "dir_0_1");
    op8(8'h00, 8'h00, 1'b1, -1, "dir_0_0_bin");
    op8(8'h80, 8'h01, 1'b0, -1, "dir_80_1");
  endtask

  task automatic test_glitch();
    op8(8'($urandom), 8'($urandom), 1'($urandom), 3, "glitch");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), -1, "random");
    end
  endtask

  task automatic test_rst_mid();
    int extra;
    a8 = 8'hC3; b8 = 8'h5A; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1;  // rst must win over a concurrent start
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8,
               bout8);
    end
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      if (done8 || busy8) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: %0d busy/done cycles after abort, want 0", extra);
    end
    op8(8'($urandom), 8'($urandom), 1'($urandom), -1, "after_rst");
  endtask

  // Exhaustive 3-bit sweep with each new start raised in the done cycle.
  task automatic test_back_to_back();
    int         cyc;
    int         got;
    int         last;
    int         expv;
    logic [6:0] v;
    logic [2:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
    v = 7'd0;
    a3 = v[2:0]; b3 = v[5:3]; bin3 = v[6]; start3 = 1'b1;
    cyc = 0; got = 0; last = 0;
    while (got < 128 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start3 = 1'b0;
      if (done3) begin
        v        = 7'(got);
        expv     = int'(v[2:0]) - int'(v[5:3]) - int'(v[6]);
        exp_diff = 3'(expv);
        exp_bout = (expv < 0);
        exp_ovf  = (v[2] ^ v[5]) & (exp_diff[2] ^ v[2]);
        checks++;
        if (diff3 !== exp_diff || bout3 !== exp_bout) begin
          errors++;
          $display("FAIL b2b vec %0d: diff=%h bout=%b, want diff=%h bout=%b", got, diff3, bout3,
                   exp_diff, exp_bout);
        end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checks++;
        if (ovf3 !== exp_ovf) begin
          errors++;
          $display("FAIL b2b_ovf vec %0d: got %b, want %b", got, ovf3, exp_ovf);
        end
`else
        if (exp_ovf) begin end
`endif
        if (got > 0) begin
          checks++;
          if (cyc - last !== 4) begin
            errors++;
            $display("FAIL b2b_gap vec %0d: %0d cycles between done pulses, want 4", got,
                     cyc - last);
          end
        end
        last = cyc;
        got++;
        if (got < 128) begin
          v = 7'(got);
          a3 = v[2:0]; b3 = v[5:3]; bin3 = v[6]; start3 = 1'b1;
        end
      end
    end
    start3 = 1'b0;
    checks++;
    if (got !== 128) begin
      errors++;
      $display("FAIL b2b_count: %0d results seen, want 128", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    test_reset();
    test_directed();
    test_glitch();
    test_rst_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
